mem_arb: RTL and testbench

Two-port arbiter and access sequencer for the MP-8 combined 32 x 8 instruction/data memory. It sits between the memory and two requesters: the fetch unit (read-only) and the load/store unit (read/write). It issues at most one memory access per cycle, returns registered read data and ensures only one requester drives the memory address, write-data and write-enable lines in a given cycle.

---
 rtl/mem_arb_if.sv | 38 +++
 rtl/mem_arb.sv | 72 +++++++
 tb/tb_mem_arb.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - fetch, load/store and memory-side signals of the MP-8 memory arbiter
interface mem_arb_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_valid;
    logic [DW-1:0] f_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    logic          busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        output f_gnt, f_valid, f_rdata, d_gnt, d_valid, d_rdata,
               mem_addr, mem_wd, mem_we, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        input  f_gnt, f_valid, f_rdata, d_gnt, d_valid, d_rdata,
               mem_addr, mem_wd, mem_we, busy
    );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-port arbiter/sequencer for the MP-8 32x8 memory; MEM_ARB_RR_EN selects round-robin on contention
module mem_arb #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic      CLK,
    input  logic      RESET,
    mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_F = 2'd1,
        ACC_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_gnt;
    logic   pick_f;

`ifdef MEM_ARB_RR_EN
    // last_gnt=1 means data was served last, so fetch takes the contested slot
    assign pick_f = last_gnt;
`else
    assign pick_f = 1'b0 & last_gnt;
`endif

    // The port being served is masked, so a held request waits one cycle
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (bus.f_req && bus.d_req) state_nxt = pick_f ? ACC_F : ACC_D;
                else if (bus.f_req)         state_nxt = ACC_F;
                else if (bus.d_req)         state_nxt = ACC_D;
            end
            ACC_F:   if (bus.d_req) state_nxt = ACC_D;
            ACC_D:   if (bus.f_req) state_nxt = ACC_F;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            last_gnt    <= 1'b0;
            bus.f_gnt   <= 1'b0;
            bus.d_gnt   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.f_valid <= 1'b0;
            bus.d_valid <= 1'b0;
            bus.f_rdata <= '0;
            bus.d_rdata <= '0;
        end else begin
            state       <= state_nxt;
            bus.f_gnt   <= (state_nxt == ACC_F);
            bus.d_gnt   <= (state_nxt == ACC_D);
            bus.busy    <= (state_nxt != IDLE);
            if (state_nxt == ACC_F)      last_gnt <= 1'b0;
            else if (state_nxt == ACC_D) last_gnt <= 1'b1;
            bus.f_valid <= bus.f_gnt;
            bus.d_valid <= bus.d_gnt;
            if (bus.f_gnt) bus.f_rdata <= bus.mem_rd;
            if (bus.d_gnt) bus.d_rdata <= bus.mem_rd;
        end
    end

    // Memory lines follow the granted port only; a write in a reset cycle is dropped
    assign bus.mem_addr = bus.f_gnt ? bus.f_addr : (bus.d_gnt ? bus.d_addr : '0);
    assign bus.mem_wd   = bus.d_gnt ? bus.d_wdata : '0;
    assign bus.mem_we   = bus.d_gnt & bus.d_we & ~RESET;
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed and randomized checks of mem_arb against a cycle-level access model
module tb_mem_arb;
    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    mem_arb_if #(.AW(5), .DW(8)) bus ();

    mem_arb #(.AW(5), .DW(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [7:0] ram [32];
    logic       load;
    logic [4:0] load_addr;
    logic [7:0] load_data;

    always @(posedge CLK) begin
        if (load)            ram[load_addr]    <= load_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wd;
    end
    assign bus.mem_rd = ram[bus.mem_addr];

    int tests  = 0;
    int errors = 0;

    // Model: which port is served in the current cycle (0 none, 1 fetch, 2 data)
    logic [7:0] ref_mem [32];
    int         served;
    int         prev;
    logic       last;
    logic       exp_fv, exp_dv;
    logic [7:0] exp_frd, exp_drd;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [4:0] ea;
        ea = (served == 1) ? bus.f_addr : (served == 2) ? bus.d_addr : 5'd0;
        chk("f_gnt",    {7'd0, bus.f_gnt},  {7'd0, served == 1});
        chk("d_gnt",    {7'd0, bus.d_gnt},  {7'd0, served == 2});
        chk("gnt_excl", {7'd0, bus.f_gnt & bus.d_gnt}, 8'd0);
        chk("busy",     {7'd0, bus.busy},   {7'd0, served != 0});
        chk("mem_addr", {3'd0, bus.mem_addr}, {3'd0, ea});
        chk("mem_wd",   bus.mem_wd, (served == 2) ? bus.d_wdata : 8'd0);
        chk("mem_we",   {7'd0, bus.mem_we}, {7'd0, (served == 2) && bus.d_we && !RESET});
        chk("f_valid",  {7'd0, bus.f_valid}, {7'd0, exp_fv});
        chk("d_valid",  {7'd0, bus.d_valid}, {7'd0, exp_dv});
        chk("f_rdata",  bus.f_rdata, exp_frd);
        chk("d_rdata",  bus.d_rdata, exp_drd);
    endtask

    // Effects of the coming rising edge, from the inputs as they stand now
    task automatic advance();
        int  nxt;
        logic ef, ed;
        if (RESET) begin
            served = 0; prev = 0; last = 1'b0;
            exp_fv = 1'b0; exp_dv = 1'b0; exp_frd = 8'd0; exp_drd = 8'd0;
            return;
        end
        exp_fv = (served == 1);
        exp_dv = (served == 2);
        if (served == 1) exp_frd = ref_mem[bus.f_addr];
        if (served == 2) begin
            exp_drd = ref_mem[bus.d_addr];
            if (bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
        end
        ef = bus.f_req && (served != 1);
        ed = bus.d_req && (served != 2);
        if (ef && ed) begin
`ifdef MEM_ARB_RR_EN
            nxt = last ? 1 : 2;
`else
            nxt = 2;
`endif
        end else if (ef) nxt = 1;
        else if (ed)     nxt = 2;
        else             nxt = 0;
        if (nxt == 1) last = 1'b0;
        if (nxt == 2) last = 1'b1;
        prev   = served;
        served = nxt;
    endtask

    task automatic tick();
        advance();
        @(negedge CLK);
        check_outputs();
    endtask

    initial begin
        RESET = 1'b1; load = 1'b1; load_addr = '0; load_data = '0;
        bus.f_req = 1'b1; bus.f_addr = '0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        served = 0; prev = 0; last = 1'b0;
        exp_fv = 1'b0; exp_dv = 1'b0; exp_frd = 8'd0; exp_drd = 8'd0;

        // Reset held with both requests up while the memory image loads
        for (int i = 0; i < 32; i++) begin
            load_addr = 5'(i);
            load_data = (i == 3) ? 8'hA5 : (i == 7) ? 8'h11 : 8'($urandom);
            ref_mem[i] = load_data;
            tick();
        end
        load = 1'b0;

        RESET = 1'b0;
        tick();
        chk("first_gnt_data", {7'd0, bus.d_gnt}, 8'd1);
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        tick(); tick();

        // Single fetch of RAM[3]
        bus.f_req = 1'b1; bus.f_addr = 5'h03;
        tick();
        chk("fetch_addr", {3'd0, bus.mem_addr}, 8'h03);
        bus.f_req = 1'b0;
        tick();
        chk("fetch_valid", {7'd0, bus.f_valid}, 8'd1);
        chk("fetch_data", bus.f_rdata, 8'hA5);
        tick();
        chk("fetch_valid_end", {7'd0, bus.f_valid}, 8'd0);

        // Write 3C to 1F then read it back
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 5'h1F; bus.d_wdata = 8'h3C;
        tick();
        chk("write_we", {7'd0, bus.mem_we}, 8'd1);
        bus.d_req = 1'b0;
        tick();
        chk("write_we_once", {7'd0, bus.mem_we}, 8'd0);
        chk("write_valid", {7'd0, bus.d_valid}, 8'd1);
        bus.d_req = 1'b1; bus.d_we = 1'b0;
        tick();
        bus.d_req = 1'b0;
        tick();
        chk("readback", bus.d_rdata, 8'h3C);
        tick();

        // One data access, idle, then contention from IDLE
        bus.d_req = 1'b1; bus.d_addr = 5'h02;
        tick();
        bus.d_req = 1'b0;
        tick(); tick();
        bus.f_req = 1'b1; bus.f_addr = 5'h04;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 5'h05; bus.d_wdata = 8'h5A;
        tick();
`ifdef MEM_ARB_RR_EN
        chk("contest_winner_f", {7'd0, bus.f_gnt}, 8'd1);
`else
        chk("contest_winner_d", {7'd0, bus.d_gnt}, 8'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("one_gnt_per_cycle", {7'd0, bus.f_gnt} + {7'd0, bus.d_gnt}, 8'd1);
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        tick(); tick();

        // Reset during the write cycle of FF to address 7
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 5'h07; bus.d_wdata = 8'hFF;
        tick();
        chk("rst_wr_gnt", {7'd0, bus.d_gnt}, 8'd1);
        RESET = 1'b1; bus.d_req = 1'b0;
        #1;
        chk("rst_we_drop", {7'd0, bus.mem_we}, 8'd0);
        tick();
        RESET = 1'b0;
        chk("rst_no_valid", {7'd0, bus.d_valid}, 8'd0);
        chk("rst_idle", {7'd0, bus.busy}, 8'd0);
        chk("rst_ram7", ram[7], 8'h11);
        tick();

        // Randomized traffic; a port holds its request until granted
        for (int i = 0; i < 400; i++) begin
            if (served != 1 && (!bus.f_req || prev == 1)) begin
                bus.f_req  = ($urandom % 3) != 0;
                bus.f_addr = 5'($urandom);
            end
            if (served != 2 && (!bus.d_req || prev == 2)) begin
                bus.d_req   = ($urandom % 3) != 0;
                bus.d_we    = 1'($urandom);
                bus.d_addr  = 5'($urandom);
                bus.d_wdata = 8'($urandom);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
